// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  p0_req;
   logic                  p0_we;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic                  p0_ack;
   logic [DATA_WIDTH-1:0] p0_rdata;

   logic                  p1_req;
   logic                  p1_we;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic                  p1_ack;
   logic [DATA_WIDTH-1:0] p1_rdata;

   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_write_enable;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_read_enable;
   logic [DATA_WIDTH-1:0] mem_read_data;

   logic                  busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_read_data,
      output p0_ack, p0_rdata, p1_ack, p1_rdata,
      output mem_address, mem_write_enable, mem_write_data, mem_read_enable,
      output busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_read_data,
      input  p0_ack, p0_rdata, p1_ack, p1_rdata,
      input  mem_address, mem_write_enable, mem_write_data, mem_read_enable,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (port 0) and execute (port 1).
// Execute has priority; a starvation counter bounds how long fetch is locked out.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned CNT_WIDTH = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

   state_e                 state;
   logic                   port_q;
   logic                   we_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [CNT_WIDTH-1:0]   lat_cnt;
   logic [CNT_WIDTH-1:0]   starve_cnt;
   logic                   mem_we_q;
   logic                   mem_re_q;
   logic                   ack0_q;
   logic                   ack1_q;
   logic                   busy_q;

   // Arbitration decision and selected request fields, only consumed in IDLE.
   logic                   grant0_c;
   logic                   sel_we_c;
   logic [ADDR_WIDTH-1:0]  sel_addr_c;
   logic [DATA_WIDTH-1:0]  sel_wdata_c;

   assign grant0_c    = !bus.p1_req ||
                        (bus.p0_req && (starve_cnt == CNT_WIDTH'(STARVE_LIMIT)));
   assign sel_we_c    = grant0_c ? bus.p0_we    : bus.p1_we;
   assign sel_addr_c  = grant0_c ? bus.p0_addr  : bus.p1_addr;
   assign sel_wdata_c = grant0_c ? bus.p0_wdata : bus.p1_wdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         port_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         data_q     <= '0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         mem_re_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.p0_req || bus.p1_req) begin
                  port_q   <= !grant0_c;
                  we_q     <= sel_we_c;
                  addr_q   <= sel_addr_c;
                  wdata_q  <= sel_wdata_c;
                  mem_we_q <= sel_we_c;
                  mem_re_q <= !sel_we_c;
                  busy_q   <= 1'b1;
                  state    <= ACCESS;
                  // Count only port-1 wins that actually kept fetch waiting.
                  if (grant0_c || !bus.p0_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt < CNT_WIDTH'(STARVE_LIMIT)) begin
                     starve_cnt <= starve_cnt + CNT_WIDTH'(1);
                  end
               end
            end
            ACCESS: begin
               if (we_q) begin
                  ack0_q <= !port_q;
                  ack1_q <= port_q;
                  state  <= DONE;
               end else begin
                  lat_cnt <= CNT_WIDTH'(MEM_LATENCY);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - CNT_WIDTH'(1);
               if (lat_cnt == CNT_WIDTH'(1)) begin
                  data_q <= bus.mem_read_data;
                  ack0_q <= !port_q;
                  ack1_q <= port_q;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.p0_ack           = ack0_q;
   assign bus.p1_ack           = ack1_q;
   assign bus.p0_rdata         = data_q;
   assign bus.p1_rdata         = data_q;
   assign bus.mem_address      = addr_q;
   assign bus.mem_write_data   = wdata_q;
   assign bus.mem_write_enable = mem_we_q;
   assign bus.mem_read_enable  = mem_re_q;
   assign bus.busy             = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory with read latency, requester
// driver, and a scoreboard of expected grant order, read data and ack spacing.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned LAT  = 3;
   localparam int unsigned SLIM = 4;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MEM_LATENCY (LAT),
      .STARVE_LIMIT(SLIM)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] rdata;
      int          spacing;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   txn_t        q0[$];
   txn_t        q1[$];
   exp_t        exp_q[$];
   logic [31:0] ref_mem [256];
   bit          ref_vld [256];
   logic [31:0] last_rd;
   bit          force_ff;

   // Power-on contents of the memory for locations never written.
   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a == 32'h40) return 32'h1234_5678;
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
   endfunction

   // Behavioural memory: data valid LAT cycles after the read-enable cycle, junk otherwise.
   logic [31:0] mem [256];
   bit          vld [256];
   logic [31:0] pipe [LAT];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return vld[a[9:2]] ? mem[a[9:2]] : init_val(a);
   endfunction

   always @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) vld[i] <= 1'b0;
      end else if (bus.mem_write_enable) begin
         mem[bus.mem_address[9:2]] <= bus.mem_write_data;
         vld[bus.mem_address[9:2]] <= 1'b1;
      end
      pipe[0] <= bus.mem_read_enable ? mem_val(bus.mem_address) : $urandom();
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
   end

   assign bus.mem_read_data = force_ff ? 32'hFFFF_FFFF : pipe[LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_vld[a[9:2]] ? ref_mem[a[9:2]] : init_val(a);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a[9:2]] = d;
      ref_vld[a[9:2]] = 1'b1;
   endtask

   task automatic drive(input bit port, input txn_t t, input bit req);
      if (port) begin
         bus.p1_req = req; bus.p1_we = t.we; bus.p1_addr = t.addr; bus.p1_wdata = t.wdata;
      end else begin
         bus.p0_req = req; bus.p0_we = t.we; bus.p0_addr = t.addr; bus.p0_wdata = t.wdata;
      end
   endtask

   // Queue a transaction; calls must be made in the expected grant order.
   task automatic add(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      txn_t t;
      exp_t e;
      t.we = we; t.addr = addr; t.wdata = wdata;
      e.port = port; e.we = we;
      e.spacing = we ? 3 : 3 + int'(LAT);
      e.rdata = we ? 32'h0 : ref_read(addr);
      if (we) ref_write(addr, wdata);
      if (port) q1.push_back(t); else q0.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic load(input bit port, output bit active);
      txn_t t;
      t.we = 1'b0; t.addr = '0; t.wdata = '0;
      active = 1'b0;
      if (port && q1.size() > 0) begin t = q1.pop_front(); active = 1'b1; end
      if (!port && q0.size() > 0) begin t = q0.pop_front(); active = 1'b1; end
      drive(port, t, active);
   endtask

   // Both requesters keep req high while they have work; acks are scored in order.
   task automatic run_ports(input string name, input int budget);
      bit          act0, act1;
      int          n;
      int          last;
      exp_t        e;
      logic [1:0]  acks;
      logic [31:0] rd;
      n = 0;
      last = -1;
      load(1'b0, act0);
      load(1'b1, act1);
      while ((act0 || act1) && n < budget) begin
         step();
         n++;
         acks = {bus.p1_ack, bus.p0_ack};
         if (acks != 2'b00) begin
            if (exp_q.size() == 0) begin
               check({name, "_spurious_ack"}, 64'(acks), 64'h0);
            end else begin
               e = exp_q.pop_front();
               check({name, "_grant"}, 64'(acks), e.port ? 64'h2 : 64'h1);
               rd = e.port ? bus.p1_rdata : bus.p0_rdata;
               if (!e.we) last_rd = e.rdata;
               check({name, "_rdata"}, 64'(rd), 64'(last_rd));
               if (last >= 0) check({name, "_spacing"}, 64'(n - last), 64'(e.spacing));
               last = n;
            end
            if (acks[0]) load(1'b0, act0);
            if (acks[1]) load(1'b1, act1);
         end
      end
      check({name, "_drained"}, 64'(exp_q.size() + q0.size() + q1.size()), 64'h0);
      exp_q.delete(); q0.delete(); q1.delete();
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
   endtask

   // One isolated request with cycle-exact checks of every control output.
   task automatic do_single(input string name, input bit port, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
      int          ack_off;
      logic [31:0] exp_rd;
      logic [4:0]  exp_ctl;
      txn_t        t;
      ack_off = we ? 2 : 2 + int'(LAT);
      exp_rd  = we ? last_rd : ref_read(addr);
      if (we) ref_write(addr, wdata);
      t.we = we; t.addr = addr; t.wdata = wdata;
      step();
      drive(port, t, 1'b1);
      for (int c = 1; c <= ack_off + 1; c++) begin
         step();
         exp_ctl[4] = port && (c == ack_off);
         exp_ctl[3] = !port && (c == ack_off);
         exp_ctl[2] = we && (c == 1);
         exp_ctl[1] = !we && (c == 1);
         exp_ctl[0] = (c <= ack_off);
         check($sformatf("%s_ctl_c%0d", name, c),
               64'({bus.p1_ack, bus.p0_ack, bus.mem_write_enable, bus.mem_read_enable, bus.busy}),
               64'(exp_ctl));
         if (c <= ack_off) check($sformatf("%s_addr_c%0d", name, c), 64'(bus.mem_address), 64'(addr));
         if (c == 1 && we) check({name, "_wdata"}, 64'(bus.mem_write_data), 64'(wdata));
         if (c == ack_off) begin
            check({name, "_p0_rdata"}, 64'(bus.p0_rdata), 64'(exp_rd));
            check({name, "_p1_rdata"}, 64'(bus.p1_rdata), 64'(exp_rd));
            drive(port, t, 1'b0);
         end
      end
      if (!we) last_rd = exp_rd;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
      last_rd  = 32'h0;
      force_ff = 1'b1;
      reset_n  = 1'b0;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h44; bus.p0_wdata = 32'hAAAA_5555;
      bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h88; bus.p1_wdata = 32'h5555_AAAA;

      // Reset held with both requests up and memory driving all ones.
      repeat (3) step();
      check("rst_acks",   64'({bus.p1_ack, bus.p0_ack}), 64'h0);
      check("rst_p0_rd",  64'(bus.p0_rdata), 64'h0);
      check("rst_p1_rd",  64'(bus.p1_rdata), 64'h0);
      check("rst_addr",   64'(bus.mem_address), 64'h0);
      check("rst_wdata",  64'(bus.mem_write_data), 64'h0);
      check("rst_enable", 64'({bus.mem_write_enable, bus.mem_read_enable}), 64'h0);
      check("rst_busy",   64'(bus.busy), 64'h0);

      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      force_ff   = 1'b0;
      reset_n    = 1'b1;
      step();

      // Start a read, then pull reset in the middle of its WAIT phase.
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h80;
      step();
      step();
      check("rst_wait_busy_before", 64'(bus.busy), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_wait_ctl", 64'({bus.p1_ack, bus.p0_ack, bus.mem_write_enable,
                                 bus.mem_read_enable, bus.busy}), 64'h0);
      bus.p1_req = 1'b0;
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         step();
         check($sformatf("rst_wait_quiet%0d", i), 64'({bus.p1_ack, bus.p0_ack, bus.busy}), 64'h0);
      end
      reset_n = 1'b1;
      step();
      check("rst_after_busy", 64'(bus.busy), 64'h0);

      do_single("p1_write", 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
      do_single("p0_read",  1'b0, 1'b0, 32'h40,  32'h0);
      do_single("p1_read",  1'b1, 1'b0, 32'h100, 32'h0);

      // Continuous contention: four execute grants, then one fetch grant.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 32'h200 + 32'(16*r + 4*i), 32'hC000_0000 + 32'(16*r + i));
         add(1'b0, 1'b0, 32'h1000 + 32'(4*r), 32'h0);
      end
      add(1'b1, 1'b1, 32'h240, 32'hC000_0040);
      add(1'b1, 1'b1, 32'h244, 32'hC000_0044);
      add(1'b0, 1'b0, 32'h1008, 32'h0);
      run_ports("contend", 200);
      step();

      // Fetch alone after two execute grants must clear the guard counter.
      add(1'b1, 1'b1, 32'h280, 32'h1111_0001);
      add(1'b1, 1'b1, 32'h284, 32'h1111_0002);
      add(1'b0, 1'b0, 32'h1010, 32'h0);
      run_ports("clear_a", 100);
      step();
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 32'h290 + 32'(4*i), 32'h2222_0000 + 32'(i));
      add(1'b0, 1'b0, 32'h1014, 32'h0);
      add(1'b1, 1'b1, 32'h2A0, 32'h2222_0004);
      run_ports("clear_b", 100);
      step();

      // Back-to-back execute reads and writes; writes must not disturb rdata.
      add(1'b1, 1'b1, 32'h300, 32'hA1A1_0001);
      add(1'b1, 1'b0, 32'h300, 32'h0);
      add(1'b1, 1'b1, 32'h300, 32'hB2B2_0002);
      add(1'b1, 1'b0, 32'h300, 32'h0);
      add(1'b1, 1'b1, 32'h304, 32'hC3C3_0003);
      add(1'b1, 1'b0, 32'h308, 32'h0);
      add(1'b1, 1'b1, 32'h30C, 32'hD4D4_0004);
      add(1'b1, 1'b0, 32'h304, 32'h0);
      run_ports("b2b", 200);

      repeat (3) step();
      check("end_idle", 64'({bus.p1_ack, bus.p0_ack, bus.busy}), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
